// File: rtl/debug_probe_pkg.sv
// debug_probe_pkg: shared state/trigger encodings and channel-slice helper for the probe capture block
package debug_probe_pkg;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] PRETRIG = 3'd1;
    localparam logic [2:0] ARMED   = 3'd2;
    localparam logic [2:0] POST    = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    localparam logic [1:0] TM_EQ     = 2'd0;
    localparam logic [1:0] TM_NE     = 2'd1;
    localparam logic [1:0] TM_EDGE   = 2'd2;
    localparam logic [1:0] TM_CHANGE = 2'd3;

    localparam int VEC_MAX = 1024;
    localparam int CH_MAX  = 64;

    function automatic logic [CH_MAX-1:0] ch_slice(
        input logic [VEC_MAX-1:0] vec,
        input int unsigned        k,
        input int unsigned        w
    );
        return CH_MAX'(vec >> (k * w)) & ({CH_MAX{1'b1}} >> (CH_MAX - w));
    endfunction

endpackage

// File: rtl/debug_probe_ram.sv
// debug_probe_ram: simple dual-port capture buffer, one write port, registered read with 1-cycle latency
module debug_probe_ram #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int W      = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [W-1:0]      wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [W-1:0]      rdata
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    // Sample storage; contents are not cleared by reset
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    // Read register holds its value when no read is issued
    always_ff @(posedge clk) begin
        if (!reset_n) rdata_q <= '0;
        else if (re) rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/debug_probe_capture.sv
// debug_probe_capture: logic-analyser capture with pre-trigger window, channel trigger and chronological readout
module debug_probe_capture
    import debug_probe_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int CH_W   = 8,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int SEL_W  = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CH*CH_W-1:0]   probe_in,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [SEL_W-1:0]         trig_ch,
    input  logic [1:0]               trig_mode,
    input  logic [CH_W-1:0]          trig_value,
    input  logic [CH_W-1:0]          trig_mask,
    input  logic [ADDR_W-1:0]        pretrig_len,
    input  logic                     arm,
    input  logic                     force_trig,
    input  logic                     rd_req,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [NUM_CH*CH_W-1:0]   rd_data,
    output logic                     rd_valid,
    output logic [2:0]               state,
    output logic                     triggered,
    output logic                     done,
    output logic [ADDR_W-1:0]        trig_addr
);

    localparam int W = NUM_CH * CH_W;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, pre_cnt_q, post_cnt_q, pre_len_q, trig_addr_q;
    logic [ADDR_W-1:0] post_len, raddr;
    logic [CH_W-1:0]   prev_q, sel;
    logic              triggered_q, rd_valid_q;
    logic              eq_sel, eq_prev, cond, capturing, fire, wr_en, rd_en;
    logic [W-1:0]      en_mask;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_en
        assign en_mask[k*CH_W +: CH_W] = {CH_W{ch_en[k]}};
    end

    // Trigger evaluation on the sample being written this cycle
    always_comb begin
        sel       = CH_W'(ch_slice(VEC_MAX'(probe_in), 32'(trig_ch), CH_W));
        eq_sel    = ((sel ^ trig_value) & trig_mask) == '0;
        eq_prev   = ((prev_q ^ trig_value) & trig_mask) == '0;
        cond      = trig_mode == TM_EQ   ? eq_sel :
                    trig_mode == TM_NE   ? !eq_sel :
                    trig_mode == TM_EDGE ? (eq_sel && !eq_prev) :
                    ((sel ^ prev_q) & trig_mask) != '0;
        capturing = state_q == PRETRIG || state_q == ARMED || state_q == POST;
        fire      = !arm && state_q == ARMED && (cond || force_trig);
        post_len  = ADDR_W'(DEPTH - 1) - pre_len_q;
    end

    // Next-state selection; arm overrides every other event
    always_comb begin
        state_d = arm ? (pretrig_len == '0 ? ARMED : PRETRIG) :
                  (state_q == PRETRIG && pre_cnt_q + 1'b1 == pre_len_q) ? ARMED :
                  fire ? (post_len == '0 ? DONE : POST) :
                  (state_q == POST && post_cnt_q == ADDR_W'(1)) ? DONE :
                  state_q;
    end

    // Buffer control and readout address in chronological order from the trigger
    always_comb begin
        wr_en     = capturing && !arm;
        rd_en     = rd_req && state_q == DONE;
        raddr     = trig_addr_q - pre_len_q + rd_addr;
        done      = state_q == DONE;
        state     = state_q;
        triggered = triggered_q;
        trig_addr = trig_addr_q;
        rd_valid  = rd_valid_q;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else state_q <= state_d;
    end

    // Pointers, counters, previous trigger sample and trigger bookkeeping
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            pre_len_q   <= '0;
            trig_addr_q <= '0;
            prev_q      <= '0;
            triggered_q <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (arm) begin
                wr_ptr_q    <= '0;
                pre_cnt_q   <= '0;
                pre_len_q   <= pretrig_len;
                prev_q      <= sel;
                triggered_q <= 1'b0;
            end else begin
                if (capturing) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                    prev_q   <= sel;
                end
                if (state_q == PRETRIG) pre_cnt_q <= pre_cnt_q + 1'b1;
                if (fire) begin
                    trig_addr_q <= wr_ptr_q;
                    triggered_q <= 1'b1;
                    post_cnt_q  <= post_len;
                end else if (state_q == POST) begin
                    post_cnt_q <= post_cnt_q - 1'b1;
                end
            end
        end
    end

    debug_probe_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .W      (W)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (wr_en),
        .waddr   (wr_ptr_q),
        .wdata   (probe_in & en_mask),
        .re      (rd_en),
        .raddr   (raddr),
        .rdata   (rd_data)
    );

endmodule

// File: tb/tb_debug_probe_capture.sv
// tb_debug_probe_capture: randomized scoreboard bench for debug_probe_capture against a sample-log reference model
module tb_debug_probe_capture;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] probe_in = '0;
    logic [7:0]  ch_en = '0;
    logic [2:0]  trig_ch = '0;
    logic [1:0]  trig_mode = '0;
    logic [7:0]  trig_value = '0;
    logic [7:0]  trig_mask = '0;
    logic [7:0]  pretrig_len = '0;
    logic        arm = 1'b0;
    logic        force_trig = 1'b0;
    logic        rd_req = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic        rd_valid;
    logic [2:0]  state;
    logic        triggered;
    logic        done;
    logic [7:0]  trig_addr;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] sb[$];
    logic [63:0] log_q[$];
    int          last_trig;
    int          last_p;

    always #5 clk = ~clk;

    debug_probe_capture dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .probe_in    (probe_in),
        .ch_en       (ch_en),
        .trig_ch     (trig_ch),
        .trig_mode   (trig_mode),
        .trig_value  (trig_value),
        .trig_mask   (trig_mask),
        .pretrig_len (pretrig_len),
        .arm         (arm),
        .force_trig  (force_trig),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .state       (state),
        .triggered   (triggered),
        .done        (done),
        .trig_addr   (trig_addr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every rd_valid must match the oldest pending expectation
    always @(negedge clk) begin
        if (reset_n && rd_valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rd_unexpected: got rd_valid=1 expected no pending read");
            end else begin
                chk("rd_data", rd_data, sb.pop_front());
            end
        end
    end

    function automatic logic [63:0] gen(input int kind, input logic [2:0] tch, input int n);
        logic [63:0] v;
        v = {$urandom, $urandom};
        if (kind == 1) v[tch*8 +: 8] = n[7:0];
        if (kind == 2 && n <= 7) v[0] = (n != 6);
        return v;
    endfunction

    function automatic logic match(input logic [1:0] mode, input logic [7:0] s, input logic [7:0] prv,
                                   input logic [7:0] tv, input logic [7:0] tm);
        logic es, ep;
        es = ((s & tm) == (tv & tm));
        ep = ((prv & tm) == (tv & tm));
        case (mode)
            2'd0:    return es;
            2'd1:    return !es;
            2'd2:    return es && !ep;
            default: return ((s ^ prv) & tm) != 0;
        endcase
    endfunction

    task automatic capture(input int p, input logic [1:0] mode, input logic [2:0] tch, input logic [7:0] tv,
                           input logic [7:0] tm, input logic [7:0] en, input int kind, input int force_at,
                           input int abort_at);
        logic [63:0] v, enx;
        logic [7:0]  prv, s;
        int          j, trig;
        for (int k = 0; k < 8; k++) enx[k*8 +: 8] = {8{en[k]}};
        ch_en = en; trig_ch = tch; trig_mode = mode; trig_value = tv; trig_mask = tm;
        pretrig_len = p[7:0];
        v = gen(kind, tch, 0);
        probe_in = v;
        prv = v[tch*8 +: 8];
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("arm_state", state, p == 0 ? 2 : 1);
        chk("arm_triggered", triggered, 0);
        chk("arm_done", done, 0);
        log_q.delete();
        trig = -1;
        j = 0;
        while (trig < 0 || log_q.size() < trig + 256 - p) begin
            if (j == abort_at) return;
            v = gen(kind, tch, j + 1);
            probe_in = v;
            force_trig = (j == force_at) || (j == p + 400);
            rd_req = (j == p);
            rd_addr = 8'($urandom);
            s = v[tch*8 +: 8];
            log_q.push_back(v & enx);
            if (trig < 0 && j >= p && (match(mode, s, prv, tv, tm) || force_trig)) trig = j;
            prv = s;
            if (trig >= 0 && log_q.size() == trig + 256 - p) chk("done_early", done, 0);
            tick();
            if (j == p) chk("armed_read_valid", rd_valid, 0);
            rd_req = 1'b0;
            force_trig = 1'b0;
            j++;
        end
        chk("done_state", state, 4);
        chk("done_flag", done, 1);
        chk("done_triggered", triggered, 1);
        chk("trig_addr", trig_addr, trig % 256);
        last_trig = trig;
        last_p = p;
    endtask

    task automatic read_back(input int extra);
        for (int i = 0; i < 6 + extra; i++) begin
            int a;
            a = i < 4 ? i : i == 4 ? last_p : i == 5 ? 255 : int'($urandom_range(0, 255));
            probe_in = {$urandom, $urandom};
            rd_req = 1'b1;
            rd_addr = a[7:0];
            sb.push_back(log_q[last_trig - last_p + a]);
            tick();
        end
        rd_req = 1'b0;
        tick();
        tick();
        chk("sb_drain", sb.size(), 0);
    endtask

    initial begin
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("rst_state", state, 0);
        chk("rst_triggered", triggered, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_trig_addr", trig_addr, 0);

        // counting channel, EQ on 0x40 with 16 pre-trigger samples
        capture(16, 2'd0, 3'd2, 8'h40, 8'hFF, 8'hFF, 1, -1, -1);
        read_back(4);

        // no natural trigger (NE with empty mask), forced on the second ARMED cycle
        capture(0, 2'd1, 3'd0, 8'h00, 8'h00, 8'hFF, 0, 1, -1);
        read_back(4);

        // rising edge on ch0 bit0, initial high level must not trigger
        capture(0, 2'd2, 3'd0, 8'h01, 8'h01, 8'hFF, 2, -1, -1);
        read_back(2);
        capture(4, 2'd2, 3'd0, 8'h01, 8'h01, 8'hFF, 2, -1, -1);
        read_back(2);

        // re-arm while post_cnt=100, then capture with upper channels disabled
        capture(10, 2'd1, 3'd1, 8'h00, 8'h00, 8'hFF, 0, 12, 158);
        capture(20, 2'd1, 3'd1, 8'h00, 8'h00, 8'h0F, 0, 50, -1);
        read_back(6);

        // randomized captures
        for (int r = 0; r < 8; r++) begin
            int p, fa;
            p = r == 0 ? 255 : r == 1 ? 1 : int'($urandom_range(0, 255));
            fa = $urandom_range(0, 1) ? -1 : int'($urandom_range(0, p + 300));
            capture(p, 2'($urandom), 3'($urandom), 8'($urandom), 8'($urandom & $urandom),
                    8'($urandom), 0, fa, -1);
            read_back(6);
        end

        // reset held for 3 clocks in the middle of POST
        capture(5, 2'd1, 3'd0, 8'h00, 8'h00, 8'hFF, 0, 10, 40);
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("midpost_rst_state", state, 0);
        chk("midpost_rst_triggered", triggered, 0);
        chk("midpost_rst_done", done, 0);
        chk("midpost_rst_rd_valid", rd_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
